div_issue_ctrl: RTL
===================

# div_issue_ctrl

Sequencer for the execute-stage divide unit. It accepts one div.w/mod.w/div.wu/mod.wu request at a time and drives the AXI-stream handshakes of the signed and unsigned divider IPs. It captures the selected quotient or remainder and holds it until the execute stage consumes it. It also absorbs pipeline flushes so that an in-flight division is drained and discarded without violating the stream protocol.

## Interface

- No parameters; data width fixed at 32, divider output 64 ({quotient, remainder}).
- clk  in  1  single clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset; sampled on posedge clk.
- req_valid  in  1  execute stage holds a valid divide-class instruction.
- req_op  in  2  [1]=unsigned, [0]=mod; 00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
- req_src1  in  32  dividend.
- req_src2  in  32  divisor.
- req_ready  out  1  controller idle, request accepted this cycle if req_valid.
- cancel  in  1  flush of the instruction owning the controller.
- res_valid  out  1  res_data holds the result of the accepted request.
- res_data  out  32  quotient (op[0]=0) or remainder (op[0]=1).
- res_ack  in  1  execute stage consumes result (es_valid & es_allowin).
- busy  out  1  state != IDLE.
- div_dividend_tdata, div_divisor_tdata  out  32  latched operands, shared by both IPs.
- sdiv_dividend_tvalid, sdiv_divisor_tvalid  out  1  signed IP input valids.
- sdiv_dividend_tready, sdiv_divisor_tready  in  1  signed IP input readies.
- sdiv_dout_tvalid  in  1; sdiv_dout_tdata  in  64  signed IP output.
- udiv_* (same six signals)  unsigned IP, same directions and widths as the sdiv_* signals.

## Operation

- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. If req_valid & ~cancel: latch op, src1, src2, clear kill, next ISSUE. If req_valid & cancel: no acceptance.
- ISSUE: the selected IP's dividend_tvalid and divisor_tvalid are driven independently. Per-channel sent flags: a channel's tvalid drops the cycle after tvalid & tready. Once both channels are sent (including simultaneously), next WAIT. Non-selected IP valids stay 0.
- AXI rule: tvalid is never withdrawn before acceptance. cancel in ISSUE sets kill and the issue continues.
- WAIT: on the selected IP's dout_tvalid, capture dout[63:32] (div) or dout[31:0] (mod) into res_data. If kill or cancel, next IDLE with the result discarded; otherwise next DONE. dout_tvalid from the non-selected IP is ignored. cancel in WAIT sets kill.
- DONE: res_valid=1. res_ack or cancel leads to IDLE. res_data stays stable until then.
- Divide by zero: the IP output is passed through unmodified; no trap.
- Operands and op are frozen from acceptance until return to IDLE. req_src changes are ignored.

## Timing

- Reset values: state IDLE, req_ready 1, busy 0, res_valid 0, res_data 0, all tvalid 0, operand regs 0, kill 0, sent flags 0.
- Reset mid-operation: IDLE on the next edge and tvalids low. The top-level also resets the IPs the same cycle.
- Request accepted at edge T: tvalids high during cycle T+1. If both treadys are high at T+1, state is WAIT at T+2.
- dout_tvalid at cycle D gives res_valid high at D+1, so result latency is IP latency + 1.
- res_ack at cycle A gives IDLE at A+1. The next request can be accepted at A+1 (one bubble).
- cancel has priority over res_ack in DONE; both lead to IDLE.
- req_valid and cancel in the same IDLE cycle: nothing accepted.

## Test plan

- Signed div: src1=0xFFFFFFF9 (-7), src2=2, op=00, treadys high, IP latency 3 → tvalids high 1 cycle; res_valid with res_data=0xFFFFFFFD (-3); held until res_ack, then IDLE.
- Unsigned mod: src1=0xFFFFFFF9, src2=2, op=11 → only udiv_* valids toggle, sdiv valids stay 0; res_data=0x00000001.
- Staggered tready: dividend_tready at T+1, divisor_tready low until T+4 → dividend_tvalid drops at T+2, divisor_tvalid stays high through T+4; WAIT at T+5; result correct.
- Cancel in ISSUE (treadys low 3 cycles, cancel pulse at T+1) → tvalids stay high until accepted; dout arrives; res_valid never asserts; IDLE and req_ready=1 the cycle after dout_tvalid.
- Cancel in DONE with res_ack low → res_valid 0 next cycle. A new request (100 div 7) then gives res_data=14.
- Reset asserted in WAIT → next cycle all outputs at reset values. A late dout_tvalid after reset produces no res_valid.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Bundle of the divide controller's request/result handshake and the stream
// ports of the signed and unsigned divider IPs.
interface div_issue_ctrl_if;
    // execute-stage request / result
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        req_ready;
    logic        cancel;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ack;
    logic        busy;

    // operands shared by both divider IPs
    logic [31:0] div_dividend_tdata;
    logic [31:0] div_divisor_tdata;

    // signed divider IP
    logic        sdiv_dividend_tvalid;
    logic        sdiv_divisor_tvalid;
    logic        sdiv_dividend_tready;
    logic        sdiv_divisor_tready;
    logic        sdiv_dout_tvalid;
    logic [63:0] sdiv_dout_tdata;

    // unsigned divider IP
    logic        udiv_dividend_tvalid;
    logic        udiv_divisor_tvalid;
    logic        udiv_dividend_tready;
    logic        udiv_divisor_tready;
    logic        udiv_dout_tvalid;
    logic [63:0] udiv_dout_tdata;

    // controller side
    modport master (
        input  req_valid, req_op, req_src1, req_src2, cancel, res_ack,
        output req_ready, res_valid, res_data, busy,
        output div_dividend_tdata, div_divisor_tdata,
        output sdiv_dividend_tvalid, sdiv_divisor_tvalid,
        input  sdiv_dividend_tready, sdiv_divisor_tready,
        input  sdiv_dout_tvalid, sdiv_dout_tdata,
        output udiv_dividend_tvalid, udiv_divisor_tvalid,
        input  udiv_dividend_tready, udiv_divisor_tready,
        input  udiv_dout_tvalid, udiv_dout_tdata
    );

    // execute stage plus divider IPs
    modport slave (
        output req_valid, req_op, req_src1, req_src2, cancel, res_ack,
        input  req_ready, res_valid, res_data, busy,
        input  div_dividend_tdata, div_divisor_tdata,
        input  sdiv_dividend_tvalid, sdiv_divisor_tvalid,
        output sdiv_dividend_tready, sdiv_divisor_tready,
        output sdiv_dout_tvalid, sdiv_dout_tdata,
        input  udiv_dividend_tvalid, udiv_divisor_tvalid,
        output udiv_dividend_tready, udiv_divisor_tready,
        output udiv_dout_tvalid, udiv_dout_tdata
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Execute-stage divide sequencer: issues one request to the signed or unsigned
// divider IP over AXI-stream, captures quotient/remainder, drains flushed work.
module div_issue_ctrl (
    input  logic             clk,
    input  logic             reset,
    div_issue_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic        kill_q, kill_d;
    logic        dvd_sent_q, dvd_sent_d;
    logic        dvs_sent_q, dvs_sent_d;
    logic [31:0] res_data_q, res_data_d;

    // Views of the IP selected by the latched op (op[1] = unsigned).
    logic        sel_unsigned;
    logic        dvd_pending;
    logic        dvs_pending;
    logic        dvd_tready_sel;
    logic        dvs_tready_sel;
    logic        dvd_fire;
    logic        dvs_fire;
    logic        dout_tvalid_sel;
    logic [63:0] dout_tdata_sel;

    always_comb begin
        sel_unsigned    = op_q[1];
        dvd_pending     = (state_q == ISSUE) && !dvd_sent_q;
        dvs_pending     = (state_q == ISSUE) && !dvs_sent_q;
        dvd_tready_sel  = sel_unsigned ? bus.udiv_dividend_tready : bus.sdiv_dividend_tready;
        dvs_tready_sel  = sel_unsigned ? bus.udiv_divisor_tready  : bus.sdiv_divisor_tready;
        dvd_fire        = dvd_pending && dvd_tready_sel;
        dvs_fire        = dvs_pending && dvs_tready_sel;
        dout_tvalid_sel = sel_unsigned ? bus.udiv_dout_tvalid : bus.sdiv_dout_tvalid;
        dout_tdata_sel  = sel_unsigned ? bus.udiv_dout_tdata  : bus.sdiv_dout_tdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            src1_q     <= 32'd0;
            src2_q     <= 32'd0;
            kill_q     <= 1'b0;
            dvd_sent_q <= 1'b0;
            dvs_sent_q <= 1'b0;
            res_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            kill_q     <= kill_d;
            dvd_sent_q <= dvd_sent_d;
            dvs_sent_q <= dvs_sent_d;
            res_data_q <= res_data_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        kill_d     = kill_q;
        dvd_sent_d = dvd_sent_q;
        dvs_sent_d = dvs_sent_q;
        res_data_d = res_data_q;

        case (state_q)
            IDLE: begin
                // A request flushed in the same cycle is never accepted.
                if (bus.req_valid && !bus.cancel) begin
                    op_d    = bus.req_op;
                    src1_d  = bus.req_src1;
                    src2_d  = bus.req_src2;
                    kill_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A flush cannot withdraw tvalid; remember it and keep issuing.
                if (bus.cancel) begin
                    kill_d = 1'b1;
                end
                dvd_sent_d = dvd_sent_q || dvd_fire;
                dvs_sent_d = dvs_sent_q || dvs_fire;
                if ((dvd_sent_q || dvd_fire) && (dvs_sent_q || dvs_fire)) begin
                    dvd_sent_d = 1'b0;
                    dvs_sent_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.cancel) begin
                    kill_d = 1'b1;
                end
                if (dout_tvalid_sel) begin
                    if (kill_q || bus.cancel) begin
                        state_d = IDLE;
                    end else begin
                        res_data_d = op_q[0] ? dout_tdata_sel[31:0] : dout_tdata_sel[63:32];
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.cancel || bus.res_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.req_ready            = (state_q == IDLE);
        bus.busy                 = (state_q != IDLE);
        bus.res_valid            = (state_q == DONE);
        bus.res_data             = res_data_q;
        bus.div_dividend_tdata   = src1_q;
        bus.div_divisor_tdata    = src2_q;
        bus.sdiv_dividend_tvalid = dvd_pending && !sel_unsigned;
        bus.sdiv_divisor_tvalid  = dvs_pending && !sel_unsigned;
        bus.udiv_dividend_tvalid = dvd_pending && sel_unsigned;
        bus.udiv_divisor_tvalid  = dvs_pending && sel_unsigned;
    end

endmodule
